// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU core and the memory responder.
// Master raises mem_req with fields stable and holds them until the one-cycle mem_ack; the slave samples only when idle and busy spans acceptance through the ack cycle.
interface mem_responder_if #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 8
) ();
   logic                 mem_req;
   logic                 mem_we;
   logic [ADDR_BITS-1:0] mem_addr;
   logic [DATA_BITS-1:0] mem_wdata;
   logic                 mem_ack;
   logic [DATA_BITS-1:0] mem_rdata;
   logic                 mem_err;
   logic                 busy;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata, mem_err, busy
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata, mem_err, busy
   );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with programmable wait states and a
// write-protected ISR region at the top of the address space.
module mem_responder #(
   parameter int                   ADDR_BITS   = 8,
   parameter int                   DATA_BITS   = 8,
   parameter int                   WAIT_CYCLES = 1,
   parameter int                   PROTECT_ISR = 1,
   parameter logic [ADDR_BITS-1:0] ISR_BASE    = 'h80
) (
   input  logic            clk,
   input  logic            reset_n,
   mem_responder_if.slave  bus,
   output logic [1:0]      o_state
);
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t               r_state;
   state_t               w_next_state;
   logic [3:0]           r_cnt;
   logic [3:0]           w_next_cnt;
   logic                 r_we;
   logic [ADDR_BITS-1:0] r_addr;
   logic [DATA_BITS-1:0] r_wdata;
   logic                 r_ack;
   logic [DATA_BITS-1:0] r_rdata;
   logic                 r_err;
   logic                 r_busy;
   logic [DATA_BITS-1:0] r_mem [0:(1<<ADDR_BITS)-1];

   logic                 w_accept;
   logic                 w_enter_ack;
   logic                 w_we;
   logic [ADDR_BITS-1:0] w_addr;
   logic [DATA_BITS-1:0] w_wdata;
   logic                 w_protected;
   logic                 w_commit;

   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (bus.mem_req) begin
               if (WAIT_CYCLES > 0) begin
                  w_next_state = ST_WAIT;
                  w_next_cnt   = CNT_INIT;
               end else begin
                  w_next_state = ST_ACK;
               end
            end
         end
         ST_WAIT: begin
            if (r_cnt == 4'd0) w_next_state = ST_ACK;
            else               w_next_cnt   = r_cnt - 4'd1;
         end
         ST_ACK:  w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // With zero wait states the ACK edge is also the accept edge, so use the live bus fields then.
   assign w_accept    = (r_state == ST_IDLE) && bus.mem_req;
   assign w_enter_ack = (w_next_state == ST_ACK) && (r_state != ST_ACK);
   assign w_we        = (r_state == ST_IDLE) ? bus.mem_we    : r_we;
   assign w_addr      = (r_state == ST_IDLE) ? bus.mem_addr  : r_addr;
   assign w_wdata     = (r_state == ST_IDLE) ? bus.mem_wdata : r_wdata;
   assign w_protected = (PROTECT_ISR != 0) && (w_addr >= ISR_BASE);
   assign w_commit    = w_enter_ack && w_we && !w_protected && reset_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_ack   <= 1'b0;
         r_rdata <= '0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
         if (w_accept) begin
            r_we    <= bus.mem_we;
            r_addr  <= bus.mem_addr;
            r_wdata <= bus.mem_wdata;
         end
         r_ack  <= w_enter_ack;
         r_err  <= w_enter_ack && w_we && w_protected;
         r_busy <= (w_next_state != ST_IDLE);
         if (w_enter_ack && !w_we) r_rdata <= r_mem[w_addr];
      end
   end

   // Storage is deliberately not reset; an aborted write never reaches it.
   always_ff @(posedge clk) begin
      if (w_commit) r_mem[w_addr] <= w_wdata;
   end

   assign bus.mem_ack   = r_ack;
   assign bus.mem_rdata = r_rdata;
   assign bus.mem_err   = r_err;
   assign bus.busy      = r_busy;
   assign o_state       = r_state;
endmodule
